// File: rtl/exception_unit.sv
// Commit-point exception sequencer: picks the winning cause, drives the CP0 update
// pulses, flushes the pipe for FLUSH_CYCLES cycles, then hands fetch a redirect.
module exception_unit #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int                FLUSH_CYCLES = 2,
    parameter int                CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic              in_bd,
    input  logic [7:0]        in_flags,
    input  logic [ADDR_W-1:0] in_badvaddr,
    input  logic              cp0_ie,
    input  logic              cp0_exl,
    input  logic [7:0]        cp0_im,
    input  logic [7:0]        cp0_ip,
    input  logic [ADDR_W-1:0] cp0_epc,
    input  logic              redirect_ready,
    output logic              flush,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              exc_commit,
    output logic [4:0]        exc_code,
    output logic [ADDR_W-1:0] exc_epc,
    output logic              exc_bd,
    output logic              exc_badv_we,
    output logic [ADDR_W-1:0] exc_badvaddr,
    output logic              eret_commit,
    output logic              busy,
    output logic [CNT_W-1:0]  exc_count
);

    typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, REDIRECT = 2'd2} state_t;

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        fcnt_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [4:0]        code_q;
    logic [ADDR_W-1:0] epc_q, badv_q, rpc_q;
    logic              bd_q, bwe_q, eret_q;

    logic              int_pend, event_in, first_flush;
    logic              cause_eret, cause_bwe;
    logic [4:0]        cause_code;
    logic [ADDR_W-1:0] cause_badv;

    assign int_pend    = cp0_ie & ~cp0_exl & (|(cp0_im & cp0_ip));
    assign event_in    = (state_q == IDLE) & in_valid & (int_pend | (|in_flags));
    assign first_flush = (state_q == FLUSH) && (fcnt_q == 4'd0);

    // Fixed priority; ERET only wins when no other cause is present.
    always_comb begin
        cause_code = 5'd0;
        cause_eret = 1'b0;
        cause_bwe  = 1'b0;
        cause_badv = '0;
        if (int_pend) begin
            cause_code = 5'd0;
        end else if (in_flags[2]) begin
            cause_code = 5'd4;
            cause_bwe  = 1'b1;
            cause_badv = in_pc;
        end else if (in_flags[3]) begin
            cause_code = 5'd10;
        end else if (in_flags[4]) begin
            cause_code = 5'd12;
        end else if (in_flags[6]) begin
            cause_code = 5'd8;
        end else if (in_flags[5]) begin
            cause_code = 5'd9;
        end else if (in_flags[1]) begin
            cause_code = 5'd4;
            cause_bwe  = 1'b1;
            cause_badv = in_badvaddr;
        end else if (in_flags[0]) begin
            cause_code = 5'd5;
            cause_bwe  = 1'b1;
            cause_badv = in_badvaddr;
        end else begin
            cause_eret = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (event_in) state_d = FLUSH;
            FLUSH:    if (fcnt_q == FLUSH_LAST) state_d = REDIRECT;
            REDIRECT: if (redirect_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            epc_q   <= '0;
            badv_q  <= '0;
            rpc_q   <= '0;
            bd_q    <= 1'b0;
            bwe_q   <= 1'b0;
            eret_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= (state_q == FLUSH) ? fcnt_q + 4'd1 : 4'd0;
            if (first_flush) cnt_q <= cnt_q + CNT_W'(1);
            if (event_in) begin
                code_q <= cause_code;
                epc_q  <= in_bd ? in_pc - ADDR_W'(4) : in_pc;
                bd_q   <= in_bd;
                bwe_q  <= cause_bwe;
                badv_q <= cause_badv;
                eret_q <= cause_eret;
                // ERET target is the EPC as seen at the event, not at redirect time.
                rpc_q  <= cause_eret ? cp0_epc : EXC_VECTOR;
            end
        end
    end

    assign flush          = (state_q == FLUSH);
    assign busy           = (state_q != IDLE);
    assign redirect_valid = (state_q == REDIRECT);
    assign redirect_pc    = rpc_q;
    assign exc_commit     = first_flush & ~eret_q;
    assign eret_commit    = first_flush & eret_q;
    assign exc_code       = code_q;
    assign exc_epc        = epc_q;
    assign exc_bd         = bd_q;
    assign exc_badv_we    = bwe_q;
    assign exc_badvaddr   = badv_q;
    assign exc_count      = cnt_q;

endmodule

// File: tb/tb_exception_unit.sv
// Bench for exception_unit: transaction-level timing model (cycles since event)
// checked every cycle, plus directed cases with literal expectations.
module tb_exception_unit;

    localparam int FC = 2;
    localparam logic [31:0] VEC = 32'hBFC0_0380;
    // Priority order, highest first: flag bit (-1 = interrupt) and its ExcCode.
    localparam int PRIO_BIT  [8] = '{-1, 2, 3, 4, 6, 5, 1, 0};
    localparam int PRIO_CODE [8] = '{ 0, 4, 10, 12, 8, 9, 4, 5};

    logic        clk = 1'b0;
    logic        rst, in_valid, in_bd, cp0_ie, cp0_exl, redirect_ready;
    logic [31:0] in_pc, in_badvaddr, cp0_epc;
    logic [7:0]  in_flags, cp0_im, cp0_ip;
    logic        flush, redirect_valid, exc_commit, exc_bd, exc_badv_we, eret_commit, busy;
    logic [31:0] redirect_pc, exc_epc, exc_badvaddr;
    logic [4:0]  exc_code;
    logic [15:0] exc_count;

    always #5 clk = ~clk;

    exception_unit #(.ADDR_W(32), .EXC_VECTOR(VEC), .FLUSH_CYCLES(FC), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_bd(in_bd),
        .in_flags(in_flags), .in_badvaddr(in_badvaddr), .cp0_ie(cp0_ie), .cp0_exl(cp0_exl),
        .cp0_im(cp0_im), .cp0_ip(cp0_ip), .cp0_epc(cp0_epc), .redirect_ready(redirect_ready),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .exc_commit(exc_commit), .exc_code(exc_code), .exc_epc(exc_epc), .exc_bd(exc_bd),
        .exc_badv_we(exc_badv_we), .exc_badvaddr(exc_badvaddr), .eret_commit(eret_commit),
        .busy(busy), .exc_count(exc_count)
    );

    typedef struct {
        logic [4:0]  code;
        logic [31:0] epc;
        logic        bd;
        logic        bwe;
        logic [31:0] badv;
        logic        eret;
        logic [31:0] tgt;
    } rec_t;

    int          n_vec, n_err;
    int          age;      // 0 = idle, else cycles elapsed since the accepted event
    rec_t        rec;
    logic [15:0] mcnt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_step();
        logic ip, found;
        int   b;
        if (!rst) begin
            age  = 0;
            mcnt = 16'h0;
            return;
        end
        if (age == 1) mcnt = mcnt + 16'h1;
        if (age == 0) begin
            ip = cp0_ie && !cp0_exl && ((cp0_im & cp0_ip) != 8'h0);
            if (in_valid && (ip || in_flags != 8'h0)) begin
                found = 1'b0;
                rec.bwe = 1'b0;
                rec.code = 5'd0;
                rec.badv = 32'h0;
                for (int k = 0; k < 8; k++) begin
                    b = PRIO_BIT[k];
                    if (!found && ((b < 0) ? ip : in_flags[b[2:0]])) begin
                        found    = 1'b1;
                        rec.code = 5'(PRIO_CODE[k]);
                        rec.bwe  = (b >= 0 && b <= 2);
                        rec.badv = (b == 2) ? in_pc : in_badvaddr;
                    end
                end
                rec.eret = !found;
                rec.epc  = in_bd ? in_pc - 32'd4 : in_pc;
                rec.bd   = in_bd;
                rec.tgt  = rec.eret ? cp0_epc : VEC;
                age = 1;
            end
        end else if (age > FC) begin
            if (redirect_ready) age = 0;
        end else begin
            age++;
        end
    endtask

    task automatic compare();
        chk("busy", 64'(busy), 64'(age != 0));
        chk("flush", 64'(flush), 64'(age >= 1 && age <= FC));
        chk("redirect_valid", 64'(redirect_valid), 64'(age > FC));
        chk("exc_commit", 64'(exc_commit), 64'(age == 1 && !rec.eret));
        chk("eret_commit", 64'(eret_commit), 64'(age == 1 && rec.eret));
        chk("exc_count", 64'(exc_count), 64'(mcnt));
        if (age != 0) begin
            chk("exc_epc", 64'(exc_epc), 64'(rec.epc));
            chk("exc_bd", 64'(exc_bd), 64'(rec.bd));
            chk("exc_badv_we", 64'(exc_badv_we), 64'(rec.bwe));
            if (!rec.eret) chk("exc_code", 64'(exc_code), 64'(rec.code));
            if (rec.bwe) chk("exc_badvaddr", 64'(exc_badvaddr), 64'(rec.badv));
        end
        if (age > FC) chk("redirect_pc", 64'(redirect_pc), 64'(rec.tgt));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic quiet();
        in_valid = 1'b0; in_flags = 8'h0; in_bd = 1'b0; in_pc = 32'h0; in_badvaddr = 32'h0;
        cp0_ie = 1'b0; cp0_exl = 1'b0; cp0_im = 8'h0; cp0_ip = 8'h0; cp0_epc = 32'h0;
        redirect_ready = 1'b1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy; i++) cycle();
        chk("wait_idle", 64'(busy), 64'h0);
    endtask

    task automatic syscall_at(input logic [31:0] pc);
        quiet();
        in_valid = 1'b1; in_pc = pc; in_flags = 8'h40;
    endtask

    initial begin
        logic [15:0] c0;
        n_vec = 0; n_err = 0; age = 0; mcnt = 16'h0;
        rec = '{code: 5'd0, epc: 32'h0, bd: 1'b0, bwe: 1'b0, badv: 32'h0, eret: 1'b0, tgt: 32'h0};
        rst = 1'b0;
        quiet();
        @(negedge clk);
        cycle(); cycle();
        chk("reset busy", 64'(busy), 64'h0);
        chk("reset redirect_pc", 64'(redirect_pc), 64'h0);
        chk("reset exc_code", 64'(exc_code), 64'h0);
        chk("reset exc_count", 64'(exc_count), 64'h0);

        // Syscall in the first cycle out of reset.
        rst = 1'b1;
        syscall_at(32'h8000_0100);
        cycle();
        quiet();
        chk("sys commit", 64'(exc_commit), 64'h1);
        chk("sys code", 64'(exc_code), 64'd8);
        chk("sys epc", 64'(exc_epc), 64'h8000_0100);
        chk("sys flush1", 64'(flush), 64'h1);
        cycle();
        chk("sys flush2", 64'(flush), 64'h1);
        chk("sys commit2", 64'(exc_commit), 64'h0);
        cycle();
        chk("sys flush3", 64'(flush), 64'h0);
        chk("sys rv", 64'(redirect_valid), 64'h1);
        chk("sys rpc", 64'(redirect_pc), 64'hBFC0_0380);
        wait_idle();

        // Delay-slot AdES.
        in_valid = 1'b1; in_pc = 32'h8000_0204; in_bd = 1'b1; in_flags = 8'h01; in_badvaddr = 32'h3;
        cycle();
        quiet();
        chk("ades code", 64'(exc_code), 64'd5);
        chk("ades epc", 64'(exc_epc), 64'h8000_0200);
        chk("ades bd", 64'(exc_bd), 64'h1);
        chk("ades bwe", 64'(exc_badv_we), 64'h1);
        chk("ades badv", 64'(exc_badvaddr), 64'h3);
        wait_idle();

        // Interrupt beats overflow+syscall; masked by EXL, overflow wins.
        for (int e = 0; e < 2; e++) begin
            in_valid = 1'b1; in_pc = 32'h8000_0300; in_flags = 8'h50;
            cp0_ie = 1'b1; cp0_exl = (e == 1); cp0_im = 8'h04; cp0_ip = 8'h04;
            cycle();
            quiet();
            chk("prio code", 64'(exc_code), (e == 0) ? 64'd0 : 64'd12);
            wait_idle();
        end

        // ERET with redirect stalled three cycles.
        in_valid = 1'b1; in_pc = 32'h8000_0500; in_flags = 8'h80; cp0_epc = 32'h8000_0400;
        redirect_ready = 1'b0;
        cycle();
        in_valid = 1'b0; in_flags = 8'h0; cp0_epc = 32'h1234_5678;
        chk("eret pulse", 64'(eret_commit), 64'h1);
        chk("eret exc_commit", 64'(exc_commit), 64'h0);
        cycle();
        for (int s = 0; s < 3; s++) begin
            cycle();
            chk("eret rv", 64'(redirect_valid), 64'h1);
            chk("eret rpc", 64'(redirect_pc), 64'h8000_0400);
        end
        redirect_ready = 1'b1;
        cycle();
        chk("eret idle", 64'(busy), 64'h0);

        // Reset mid-REDIRECT, then an immediate new syscall.
        syscall_at(32'h8000_0600);
        redirect_ready = 1'b0;
        cycle();
        in_valid = 1'b0;
        cycle(); cycle();
        rst = 1'b0;
        cycle();
        chk("rst rv", 64'(redirect_valid), 64'h0);
        chk("rst rpc", 64'(redirect_pc), 64'h0);
        chk("rst count", 64'(exc_count), 64'h0);
        chk("rst epc", 64'(exc_epc), 64'h0);
        rst = 1'b1;
        syscall_at(32'h8000_0700);
        cycle();
        quiet();
        chk("post-rst commit", 64'(exc_commit), 64'h1);
        cycle();
        chk("post-rst count", 64'(exc_count), 64'h1);
        wait_idle();

        // Events held while busy are dropped.
        c0 = mcnt;
        syscall_at(32'h8000_0800);
        cycle(); cycle(); cycle();
        quiet();
        wait_idle();
        chk("b2b count", 64'(exc_count), 64'(c0 + 16'd1));

        // Counter wrap.
        force dut.cnt_q = 16'hFFFF;
        #1 release dut.cnt_q;
        mcnt = 16'hFFFF;
        syscall_at(32'h8000_0900);
        cycle();
        quiet();
        chk("wrap pre", 64'(exc_count), 64'hFFFF);
        cycle();
        chk("wrap", 64'(exc_count), 64'h0);
        wait_idle();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom_range(149) != 0);
            in_valid       = $urandom_range(1);
            in_pc          = $urandom & 32'hFFFF_FFFC;
            in_bd          = $urandom_range(1);
            in_badvaddr    = $urandom;
            case ($urandom_range(3))
                0, 1:    in_flags = 8'h0;
                2:       in_flags = 8'(1 << $urandom_range(7));
                default: in_flags = 8'($urandom);
            endcase
            cp0_ie         = $urandom_range(1);
            cp0_exl        = ($urandom_range(3) == 0);
            cp0_im         = 8'($urandom);
            cp0_ip         = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h0;
            cp0_epc        = $urandom;
            redirect_ready = ($urandom_range(9) < 7);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
